// File: rtl/uart_tx_cfg_if.sv
// ----------------------------------------------------------------------------
// uart_tx_cfg_if
// Purpose : Bundles the character handshake and serial-side status of the
//           configurable UART transmitter.
// Signals : s_data   character to send (LSB first on the line)
//           s_valid  s_data is valid
//           s_ready  transmitter can accept a character
//           tx       serial line, idle high
//           busy     frame in progress
//           tx_done  one-cycle pulse when a frame completes
// Modports: master = byte source, slave = transmitter.
// ----------------------------------------------------------------------------
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic                 tx;
  logic                 busy;
  logic                 tx_done;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready,
    input  tx,
    input  busy,
    input  tx_done
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready,
    output tx,
    output busy,
    output tx_done
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// ----------------------------------------------------------------------------
// uart_tx_cfg
// Purpose : Parametrised UART transmitter. Accepts one character per
//           valid/ready handshake and serialises it as
//           start, DATA_BITS data bits (LSB first), optional parity,
//           STOP_BITS stop bits. Each bit lasts CLKS_PER_BIT clocks.
// Ports   : clk  - single clock, posedge
//           rst  - synchronous active-high reset
//           bus  - uart_tx_cfg_if.slave (s_data, s_valid, s_ready, tx, busy,
//                  tx_done)
// Params  : CLKS_PER_BIT 2..65535, DATA_BITS 5..9,
//           PARITY 0 none / 1 odd / 2 even, STOP_BITS 1..2
// ----------------------------------------------------------------------------
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_cfg_if.slave bus
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
    $error("uart_tx_cfg: CLKS_PER_BIT must be in 2..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  // Index covers data bits (up to 9) and stop bits.
  localparam int IDX_W = 4;

  localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state;
  logic [TMR_W-1:0]     r_timer;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_tx;
  logic                 r_done;

  state_t               w_state_n;
  logic [TMR_W-1:0]     w_timer_n;
  logic [IDX_W-1:0]     w_idx_n;
  logic [DATA_BITS-1:0] w_data_n;
  logic                 w_tx_n;
  logic                 w_done_n;
  logic                 w_bit_end;
  logic                 w_accept;
  logic                 w_par;
  logic [DATA_BITS-1:0] w_data_shift;

  assign w_bit_end = (r_timer == LAST_TICK);
  assign w_accept  = bus.s_valid && bus.s_ready;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  assign w_par        = (^w_data_n) ^ (PARITY == 1);
  assign w_data_shift = w_data_n >> w_idx_n;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_timer <= w_timer_n;
      r_idx   <= w_idx_n;
      r_data  <= w_data_n;
      r_tx    <= w_tx_n;
      r_done  <= w_done_n;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_n = r_state;
    w_timer_n = r_timer;
    w_idx_n   = r_idx;
    w_data_n  = r_data;
    w_done_n  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_timer_n = '0;
        w_idx_n   = '0;
        if (w_accept) begin
          w_data_n  = bus.s_data;
          w_state_n = S_START;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_timer_n = '0;
          w_idx_n   = '0;
          w_state_n = S_DATA;
        end else begin
          w_timer_n = r_timer + 1'b1;
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          w_timer_n = '0;
          if (r_idx == LAST_DATA) begin
            w_idx_n   = '0;
            w_state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            w_idx_n = r_idx + 1'b1;
          end
        end else begin
          w_timer_n = r_timer + 1'b1;
        end
      end

      S_PARITY: begin
        if (w_bit_end) begin
          w_timer_n = '0;
          w_idx_n   = '0;
          w_state_n = S_STOP;
        end else begin
          w_timer_n = r_timer + 1'b1;
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          w_timer_n = '0;
          if (r_idx == LAST_STOP) begin
            w_idx_n   = '0;
            w_state_n = S_IDLE;
            w_done_n  = 1'b1;
          end else begin
            w_idx_n = r_idx + 1'b1;
          end
        end else begin
          w_timer_n = r_timer + 1'b1;
        end
      end

      default: begin
        w_state_n = S_IDLE;
        w_timer_n = '0;
        w_idx_n   = '0;
      end
    endcase
  end

  // The line level is registered from the next state so tx changes in the
  // same cycle the state does, and only at bit boundaries.
  always_comb begin
    w_tx_n = 1'b1;
    case (w_state_n)
      S_IDLE:   w_tx_n = 1'b1;
      S_START:  w_tx_n = 1'b0;
      S_DATA:   w_tx_n = w_data_shift[0];
      S_PARITY: w_tx_n = w_par;
      S_STOP:   w_tx_n = 1'b1;
      default:  w_tx_n = 1'b1;
    endcase
  end

  assign bus.s_ready = (r_state == S_IDLE) && !rst;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.tx      = r_tx;
  assign bus.tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_cfg
// Self-checking bench for uart_tx_cfg. Five transmitter configurations share
// one clock and reset; a selector routes the handshake to one of them and
// brings its outputs back as {tx, busy, tx_done, s_ready}. Expected values
// come from a frame model built from the character format rules.
// ----------------------------------------------------------------------------
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst;
  logic       drv_valid;
  logic [8:0] drv_data;
  int         sel;
  logic [3:0] obs;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  // 0: C=4 8N1   1: C=4 8E1   2: C=4 8O1   3: C=3 7N2   4: C=2 9E1
  uart_tx_cfg_if #(.DATA_BITS(8)) if_n1 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if_e1 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if_o1 ();
  uart_tx_cfg_if #(.DATA_BITS(7)) if_72 ();
  uart_tx_cfg_if #(.DATA_BITS(9)) if_9e ();

  assign if_n1.s_valid = drv_valid && (sel == 0);
  assign if_e1.s_valid = drv_valid && (sel == 1);
  assign if_o1.s_valid = drv_valid && (sel == 2);
  assign if_72.s_valid = drv_valid && (sel == 3);
  assign if_9e.s_valid = drv_valid && (sel == 4);
  assign if_n1.s_data  = drv_data[7:0];
  assign if_e1.s_data  = drv_data[7:0];
  assign if_o1.s_data  = drv_data[7:0];
  assign if_72.s_data  = drv_data[6:0];
  assign if_9e.s_data  = drv_data;

  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    u_n1 (.clk(clk), .rst(rst), .bus(if_n1.slave));
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    u_e1 (.clk(clk), .rst(rst), .bus(if_e1.slave));
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
    u_o1 (.clk(clk), .rst(rst), .bus(if_o1.slave));
  uart_tx_cfg #(.CLKS_PER_BIT(3), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2))
    u_72 (.clk(clk), .rst(rst), .bus(if_72.slave));
  uart_tx_cfg #(.CLKS_PER_BIT(2), .DATA_BITS(9), .PARITY(2), .STOP_BITS(1))
    u_9e (.clk(clk), .rst(rst), .bus(if_9e.slave));

  always_comb begin
    obs = 4'b0000;
    case (sel)
      0: obs = {if_n1.tx, if_n1.busy, if_n1.tx_done, if_n1.s_ready};
      1: obs = {if_e1.tx, if_e1.busy, if_e1.tx_done, if_e1.s_ready};
      2: obs = {if_o1.tx, if_o1.busy, if_o1.tx_done, if_o1.s_ready};
      3: obs = {if_72.tx, if_72.busy, if_72.tx_done, if_72.s_ready};
      4: obs = {if_9e.tx, if_9e.busy, if_9e.tx_done, if_9e.s_ready};
      default: obs = 4'b0000;
    endcase
  end

  // ---------------- reference model ----------------
  function automatic void get_cfg(input int s, output int c, output int db,
                                  output int par, output int sb);
    c = 4; db = 8; par = 0; sb = 1;
    case (s)
      1: par = 2;
      2: par = 1;
      3: begin c = 3; db = 7; sb = 2; end
      4: begin c = 2; db = 9; par = 2; end
      default: ;
    endcase
  endfunction

  function automatic int frame_cycles(input int s);
    int c, db, par, sb;
    get_cfg(s, c, db, par, sb);
    return (1 + db + ((par != 0) ? 1 : 0) + sb) * c;
  endfunction

  // Expected {tx, busy, tx_done, s_ready} j cycles after the first cycle
  // following the handshake (j = 0 is the first start-bit cycle).
  function automatic logic [3:0] exp_vec(input int s, input logic [8:0] d,
                                         input int j);
    int c, db, par, sb, k, ones;
    logic b;
    get_cfg(s, c, db, par, sb);
    if (j >= frame_cycles(s))
      return {1'b1, 1'b0, (j == frame_cycles(s)) ? 1'b1 : 1'b0, 1'b1};
    k = j / c;
    ones = 0;
    for (int i = 0; i < db; i++) ones += int'(d[i]);
    if (k == 0)                          b = 1'b0;
    else if (k <= db)                    b = d[k-1];
    else if (par != 0 && k == db + 1)    b = ((ones % 2) == ((par == 1) ? 0 : 1));
    else                                 b = 1'b1;
    return {b, 1'b1, 1'b0, 1'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_frame(input int s, input logic [8:0] d, input string name);
    logic [3:0] e;
    sel = s;
    drv_data = d;
    drv_valid = 1'b1;
    #1;
    n_checks++;
    if (obs[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before_handshake: got %b, expected 1", name, obs[0]);
    end
    step();
    drv_valid = 1'b0;
    for (int j = 0; j <= frame_cycles(s); j++) begin
      if (j > 0) step();
      e = exp_vec(s, d, j);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s cycle T+%0d tx/busy/done/ready: got %b, expected %b",
                 name, j + 1, obs, e);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drv_valid = 1'b0;
    step();
    step();
    for (int s = 0; s < 5; s++) begin
      sel = s;
      #1;
      n_checks++;
      if (obs !== 4'b1000) begin
        n_fail++;
        $display("FAIL reset_held cfg%0d: got %b, expected 1000", s, obs);
      end
    end
    rst = 1'b0;
    step();
    for (int s = 0; s < 5; s++) begin
      sel = s;
      #1;
      n_checks++;
      if (obs !== 4'b1001) begin
        n_fail++;
        $display("FAIL reset_released cfg%0d: got %b, expected 1001", s, obs);
      end
    end
  endtask

  task automatic test_8n1();
    test_frame(0, 9'h0A5, "n1_A5");
    for (int i = 0; i < 3; i++) test_frame(0, 9'($urandom_range(0, 255)), "n1_rand");
  endtask

  task automatic test_parity();
    test_frame(1, 9'h007, "e1_07");
    test_frame(2, 9'h007, "o1_07");
    for (int i = 0; i < 2; i++) begin
      test_frame(1, 9'($urandom_range(0, 255)), "e1_rand");
      test_frame(2, 9'($urandom_range(0, 255)), "o1_rand");
    end
  endtask

  task automatic test_7bit_2stop();
    test_frame(3, 9'h055, "72_55");
    for (int i = 0; i < 3; i++) test_frame(3, 9'($urandom_range(0, 127)), "72_rand");
  endtask

  task automatic test_9bit_min();
    test_frame(4, 9'h1AB, "9e_1AB");
    for (int i = 0; i < 3; i++) test_frame(4, 9'($urandom_range(0, 511)), "9e_rand");
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    int fc;
    fc = frame_cycles(0);
    sel = 0;
    step();
    drv_data = 9'h000;
    drv_valid = 1'b1;
    step();
    // s_valid stays high with scrambled data until the idle cycle.
    for (int j = 0; j <= fc; j++) begin
      if (j > 0) step();
      e = exp_vec(0, 9'h000, j);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL b2b_first cycle T+%0d: got %b, expected %b", j + 1, obs, e);
      end
      drv_data = (j == fc) ? 9'h0FF : 9'($urandom_range(0, 255));
    end
    step();
    drv_valid = 1'b0;
    for (int j = 0; j <= fc; j++) begin
      if (j > 0) step();
      e = exp_vec(0, 9'h0FF, j);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL b2b_second cycle T+%0d: got %b, expected %b",
                 fc + j + 2, obs, e);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [3:0] e;
    sel = 0;
    step();
    drv_data = 9'h0A5;
    drv_valid = 1'b1;
    step();
    drv_valid = 1'b0;
    for (int j = 0; j < 15; j++) begin
      if (j > 0) step();
      e = exp_vec(0, 9'h0A5, j);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL midrst_pre cycle T+%0d: got %b, expected %b", j + 1, obs, e);
      end
    end
    rst = 1'b1;
    step();
    n_checks++;
    if (obs !== 4'b1000) begin
      n_fail++;
      $display("FAIL midrst_T+16: got %b, expected 1000", obs);
    end
    rst = 1'b0;
    for (int j = 0; j < 45; j++) begin
      step();
      n_checks++;
      if (obs !== 4'b1001) begin
        n_fail++;
        $display("FAIL midrst_idle cycle %0d: got %b, expected 1001", j, obs);
      end
    end
    test_frame(0, 9'h03C, "midrst_3C");
  endtask

  task automatic test_reset_with_valid();
    sel = 1;
    step();
    rst = 1'b1;
    drv_valid = 1'b1;
    drv_data = 9'($urandom_range(0, 255));
    step();
    n_checks++;
    if (obs !== 4'b1000) begin
      n_fail++;
      $display("FAIL rst_valid_edge: got %b, expected 1000", obs);
    end
    rst = 1'b0;
    drv_valid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      step();
      n_checks++;
      if (obs !== 4'b1001) begin
        n_fail++;
        $display("FAIL rst_valid_idle cycle %0d: got %b, expected 1001", j, obs);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drv_valid = 1'b0;
    drv_data = '0;
    sel = 0;
    test_reset();
    test_8n1();
    test_parity();
    test_7bit_2stop();
    test_9bit_min();
    test_back_to_back();
    test_reset_midframe();
    test_reset_with_valid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
